// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio noise gate.
//   sample_t      signed 16-bit audio word
//   gain_t        unsigned 9-bit gain, 0..GAIN_UNITY (256 = unity)
//   env_t         15-bit magnitude envelope (|sample| saturated to 32767)
//   gate_state_t  CLOSED, ATTACK, OPEN, HOLD, RELEASE
//   abs_sat()     saturating absolute value, -32768 maps to 32767
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 9;
  localparam int ENV_W      = SAMPLE_W - 1;
  localparam int GAIN_SHIFT = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [GAIN_W-1:0]   gain_t;
  typedef logic        [ENV_W-1:0]    env_t;

  localparam gain_t   GAIN_UNITY = gain_t'(256);
  localparam sample_t SAMPLE_MIN = sample_t'(16'h8000);

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

  // The most negative sample has no positive twin in 16 bits, so it clips.
  function automatic env_t abs_sat(input sample_t s);
    env_t mag;
    if (s == SAMPLE_MIN)       mag = '1;
    else if (s[SAMPLE_W-1])    mag = env_t'(-s);
    else                       mag = env_t'(s);
    return mag;
  endfunction

endpackage

// File: rtl/gate_gain_mul.sv
// -----------------------------------------------------------------------------
// gate_gain_mul
// Registered gain stage for one audio channel: result = (sample * gain) >>> 8,
// or the raw sample when bypass is set. One cycle of latency.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   stb           sample valid this cycle
//   sample        signed input sample
//   gain          unsigned gain, 0..256
//   bypass        1 = pass sample unmodified
//   result        registered output sample
//   result_stb    one-cycle strobe, result updated
// -----------------------------------------------------------------------------
module gate_gain_mul
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    stb,
  input  sample_t sample,
  input  gain_t   gain,
  input  logic    bypass,
  output sample_t result,
  output logic    result_stb
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] prod;
  sample_t                  scaled;

  // Gain is zero-extended so it multiplies as a positive signed value.
  assign prod = $signed({{(GAIN_W + 1){sample[SAMPLE_W-1]}}, sample})
              * $signed({{(SAMPLE_W + 1){1'b0}}, gain});

  // Arithmetic shift floors toward -inf; gain <= 256 keeps the result in 16 bits.
  assign scaled = sample_t'(prod >>> GAIN_SHIFT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      result_stb <= 1'b0;
    end else begin
      result_stb <= stb;
      if (stb) result <= bypass ? sample : scaled;
    end
  end

endmodule

// File: rtl/audio_noise_gate.sv
// -----------------------------------------------------------------------------
// audio_noise_gate
// Stereo noise gate between the codec capture logic and the record/playback
// path. Stage 1 captures each sample and updates a shared peak envelope;
// stage 2 applies the gate gain. A per-frame FSM ramps the gain up when the
// envelope exceeds the threshold and back down after a hold period.
// Optional build macro:
//   NOISE_GATE_HYST_EN  close threshold = threshold >> 1 (hysteresis);
//                       otherwise the close threshold equals threshold.
// Ports:
//   CLOCK_50                system clock
//   RST                     synchronous reset, active-high
//   audio_inL/audio_inR     signed samples, valid with ADC_STBL/ADC_STBR
//   ADC_STBL/ADC_STBR       one-cycle strobes; ADC_STBR ends a frame
//   threshold               open threshold on the |sample| envelope
//   bypass                  1 = pass samples unmodified (same latency)
//   audio_outL/audio_outR   gated samples, 2 cycles after the input strobe
//   out_stbL/out_stbR       one-cycle output strobes
//   gate_open               1 in ATTACK, OPEN or HOLD
// -----------------------------------------------------------------------------
module audio_noise_gate
  import audio_pkg::*;
#(
  parameter int DECAY_SHIFT  = 4,
  parameter int ATTACK_STEP  = 32,
  parameter int RELEASE_STEP = 4,
  parameter int HOLD_FRAMES  = 4800
) (
  input  logic               CLOCK_50,
  input  logic               RST,
  input  logic signed [15:0] audio_inL,
  input  logic signed [15:0] audio_inR,
  input  logic               ADC_STBL,
  input  logic               ADC_STBR,
  input  logic        [14:0] threshold,
  input  logic               bypass,
  output logic signed [15:0] audio_outL,
  output logic signed [15:0] audio_outR,
  output logic               out_stbL,
  output logic               out_stbR,
  output logic               gate_open
);

  localparam gain_t       ATTACK_INC  = gain_t'(ATTACK_STEP);
  localparam gain_t       RELEASE_DEC = gain_t'(RELEASE_STEP);
  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_FRAMES - 1);

  sample_t           samp_l, samp_r;
  logic              stb1_l, stb1_r;
  env_t              env, env_next, peak, close_thr;
  gate_state_t       state;
  gain_t             gain, gain_up, gain_dn;
  logic [GAIN_W:0]   gain_sum;
  logic [15:0]       hold_cnt;

`ifdef NOISE_GATE_HYST_EN
  assign close_thr = threshold >> 1;
`else
  assign close_thr = threshold;
`endif

  // Simultaneous strobes collapse into a single envelope update on the larger
  // magnitude, so the decay rate per strobe event stays the same.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    peak     = '0;
    env_next = env;
    if (ADC_STBL) peak = abs_sat(audio_inL);
    if (ADC_STBR && (abs_sat(audio_inR) > peak)) peak = abs_sat(audio_inR);
    if (ADC_STBL || ADC_STBR)
      env_next = (peak > env) ? peak : env - (env >> DECAY_SHIFT);
  end

  assign gain_sum = {1'b0, gain} + {1'b0, ATTACK_INC};
  assign gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[GAIN_W-1:0];
  assign gain_dn  = (gain > RELEASE_DEC) ? gain - RELEASE_DEC : '0;

  // Stage 1: capture samples and track the envelope.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      samp_l <= '0;
      samp_r <= '0;
      stb1_l <= 1'b0;
      stb1_r <= 1'b0;
      env    <= '0;
    end else begin
      stb1_l <= ADC_STBL;
      stb1_r <= ADC_STBR;
      if (ADC_STBL) samp_l <= audio_inL;
      if (ADC_STBR) samp_r <= audio_inR;
      env <= env_next;
    end
  end

  // Gate FSM, evaluated once per frame while the right sample sits in stage 1
  // (env already holds that frame's update). Entering ATTACK applies the first
  // gain step immediately, so a full ramp takes 256/ATTACK_STEP frames from
  // the frame that opened the gate.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
    end else if (stb1_r) begin
      case (state)
        CLOSED: begin
          gain <= '0;
          if (env >= threshold) begin
            state     <= ATTACK;
            gain      <= gain_up;
            gate_open <= 1'b1;
          end
        end
        ATTACK: begin
          if (env < close_thr) begin
            state     <= RELEASE;
            gate_open <= 1'b0;
          end else begin
            gain <= gain_up;
            if (gain_up == GAIN_UNITY) state <= OPEN;
          end
        end
        OPEN: begin
          gain <= GAIN_UNITY;
          if (env < close_thr) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (env >= threshold) begin
            state <= OPEN;
          end else if (hold_cnt == '0) begin
            state     <= RELEASE;
            gate_open <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        RELEASE: begin
          if (env >= threshold) begin
            state     <= ATTACK;
            gain      <= gain_up;
            gate_open <= 1'b1;
          end else begin
            gain <= gain_dn;
            if (gain_dn == '0) state <= CLOSED;
          end
        end
        default: begin
          state     <= CLOSED;
          gain      <= '0;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: independent gain stages per channel, using the gain register
  // as it stands when the sample leaves stage 1.
  gate_gain_mul u_mul_l (
    .clk        (CLOCK_50),
    .rst        (RST),
    .stb        (stb1_l),
    .sample     (samp_l),
    .gain       (gain),
    .bypass     (bypass),
    .result     (audio_outL),
    .result_stb (out_stbL)
  );

  gate_gain_mul u_mul_r (
    .clk        (CLOCK_50),
    .rst        (RST),
    .stb        (stb1_r),
    .sample     (samp_r),
    .gain       (gain),
    .bypass     (bypass),
    .result     (audio_outR),
    .result_stb (out_stbR)
  );

endmodule
